// File: rtl/hazard_ctrl_if.sv
// Hazard-controller bundle: ID/EX hazard fields and stall inputs toward the controller,
// pipeline-register enables, flushes, action state and statistics back from it.
interface hazard_ctrl_if #(
   parameter int CNT_W = 16
);
   logic [4:0]       id_rs;
   logic [4:0]       id_rt;
   logic             id_uses_rt;
   logic             idex_MemRead;
   logic [4:0]       idex_rt;
   logic             ex_branch_taken;
   logic             ext_stall;
   logic             pc_write;
   logic             ifid_write;
   logic             ifid_flush;
   logic             idex_flush;
   logic             pipe_freeze;
   logic [1:0]       state;
   logic [CNT_W-1:0] stall_cnt;
   logic [CNT_W-1:0] flush_cnt;
   logic             freeze_timeout;

   modport master (
      output id_rs, id_rt, id_uses_rt, idex_MemRead, idex_rt, ex_branch_taken, ext_stall,
      input  pc_write, ifid_write, ifid_flush, idex_flush, pipe_freeze,
      input  state, stall_cnt, flush_cnt, freeze_timeout
   );

   modport slave (
      input  id_rs, id_rt, id_uses_rt, idex_MemRead, idex_rt, ex_branch_taken, ext_stall,
      output pc_write, ifid_write, ifid_flush, idex_flush, pipe_freeze,
      output state, stall_cnt, flush_cnt, freeze_timeout
   );
endinterface

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: picks RUN/STALL/FLUSH/FREEZE each cycle with combinational
// control outputs; action state, saturating statistics and sticky freeze timeout lag by 1 cycle.
module hazard_ctrl #(
   parameter int CNT_W      = 16,
   parameter int FREEZE_MAX = 64
) (
   input  logic          clk,
   input  logic          reset,
   hazard_ctrl_if.slave  bus
);
   localparam int FR_W = $clog2(FREEZE_MAX) + 1;

   typedef enum logic [1:0] {
      ACT_RUN    = 2'd0,
      ACT_STALL  = 2'd1,
      ACT_FLUSH  = 2'd2,
      ACT_FREEZE = 2'd3
   } act_t;

   act_t             state_q, state_d;
   logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
   logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;
   logic [FR_W-1:0]  freeze_run_q, freeze_run_d;
   logic             freeze_timeout_q, freeze_timeout_d;

   logic hz;
   act_t act;

   always_comb begin
      hz = bus.idex_MemRead & (bus.idex_rt != 5'd0) &
           ((bus.idex_rt == bus.id_rs) | (bus.id_uses_rt & (bus.idex_rt == bus.id_rt)));

      if (bus.ext_stall)            act = ACT_FREEZE;
      else if (bus.ex_branch_taken) act = ACT_FLUSH;
      else if (hz)                  act = ACT_STALL;
      else                          act = ACT_RUN;
   end

   // Reset overrides every action so a held reset can never clock the pipeline.
   always_comb begin
      bus.pc_write    = 1'b0;
      bus.ifid_write  = 1'b0;
      bus.ifid_flush  = 1'b0;
      bus.idex_flush  = 1'b0;
      bus.pipe_freeze = 1'b0;
      if (reset) begin
         unique case (act)
            ACT_RUN: begin
               bus.pc_write   = 1'b1;
               bus.ifid_write = 1'b1;
            end
            ACT_STALL: begin
               bus.idex_flush = 1'b1;
            end
            ACT_FLUSH: begin
               bus.pc_write   = 1'b1;
               bus.ifid_write = 1'b1;
               bus.ifid_flush = 1'b1;
               bus.idex_flush = 1'b1;
            end
            ACT_FREEZE: begin
               bus.pipe_freeze = 1'b1;
            end
            default: ;
         endcase
      end
   end

   always_comb begin
      state_d     = act;
      stall_cnt_d = stall_cnt_q;
      flush_cnt_d = flush_cnt_q;
      if (act == ACT_STALL && stall_cnt_q != {CNT_W{1'b1}})
         stall_cnt_d = stall_cnt_q + CNT_W'(1);
      if (act == ACT_FLUSH && flush_cnt_q != {CNT_W{1'b1}})
         flush_cnt_d = flush_cnt_q + CNT_W'(1);

      freeze_run_d = '0;
      if (act == ACT_FREEZE) begin
         if (freeze_run_q != FR_W'(FREEZE_MAX))
            freeze_run_d = freeze_run_q + FR_W'(1);
         else
            freeze_run_d = freeze_run_q;
      end
      freeze_timeout_d = freeze_timeout_q | (freeze_run_d == FR_W'(FREEZE_MAX));
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q          <= ACT_RUN;
         stall_cnt_q      <= '0;
         flush_cnt_q      <= '0;
         freeze_run_q     <= '0;
         freeze_timeout_q <= 1'b0;
      end else begin
         state_q          <= state_d;
         stall_cnt_q      <= stall_cnt_d;
         flush_cnt_q      <= flush_cnt_d;
         freeze_run_q     <= freeze_run_d;
         freeze_timeout_q <= freeze_timeout_d;
      end
   end

   assign bus.state          = state_q;
   assign bus.stall_cnt      = stall_cnt_q;
   assign bus.flush_cnt      = flush_cnt_q;
   assign bus.freeze_timeout = freeze_timeout_q;
endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed table-driven bench for hazard_ctrl with CNT_W=2 and FREEZE_MAX=4.
module tb_hazard_ctrl;
   localparam int CNT_W = 2;

   // Control vector order: {pc_write, ifid_write, ifid_flush, idex_flush, pipe_freeze}
   localparam logic [4:0] C_RUN = 5'b11000;
   localparam logic [4:0] C_STL = 5'b00010;
   localparam logic [4:0] C_FLS = 5'b11110;
   localparam logic [4:0] C_FRZ = 5'b00001;
   localparam logic [4:0] C_OFF = 5'b00000;

   typedef struct {
      logic       rst;
      logic       ext;
      logic       br;
      logic       mr;
      logic [4:0] xrt;
      logic [4:0] rs;
      logic [4:0] rt;
      logic       uses;
      logic [4:0] ctrl;
      logic [1:0] st;
      logic [1:0] sc;
      logic [1:0] fc;
      logic       tmo;
   } vec_t;

   logic clk = 1'b0;
   logic reset;
   int   checks = 0;
   int   errors = 0;
   vec_t tbl[$];

   hazard_ctrl_if #(.CNT_W(CNT_W)) bus ();

   hazard_ctrl #(.CNT_W(CNT_W), .FREEZE_MAX(4)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   function automatic vec_t mk(input logic rst, ext, br, mr, input logic [4:0] xrt, rs, rt,
                               input logic uses, input logic [4:0] ctrl, input logic [1:0] st,
                               input logic [1:0] sc, fc, input logic tmo);
      vec_t v;
      v.rst = rst; v.ext = ext; v.br = br; v.mr = mr; v.xrt = xrt; v.rs = rs; v.rt = rt;
      v.uses = uses; v.ctrl = ctrl; v.st = st; v.sc = sc; v.fc = fc; v.tmo = tmo;
      return v;
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic drive(input vec_t v);
      reset               = v.rst;
      bus.ext_stall       = v.ext;
      bus.ex_branch_taken = v.br;
      bus.idex_MemRead    = v.mr;
      bus.idex_rt         = v.xrt;
      bus.id_rs           = v.rs;
      bus.id_rt           = v.rt;
      bus.id_uses_rt      = v.uses;
   endtask

   task automatic apply(input vec_t v, input string tag);
      logic [4:0] ctrl;
      @(negedge clk);
      drive(v);
      #1;
      ctrl = {bus.pc_write, bus.ifid_write, bus.ifid_flush, bus.idex_flush, bus.pipe_freeze};
      check({tag, " ctrl"}, 32'(ctrl), 32'(v.ctrl));
      @(posedge clk);
      #1;
      check({tag, " state"}, 32'(bus.state), 32'(v.st));
      check({tag, " stall_cnt"}, 32'(bus.stall_cnt), 32'(v.sc));
      check({tag, " flush_cnt"}, 32'(bus.flush_cnt), 32'(v.fc));
      check({tag, " freeze_timeout"}, 32'(bus.freeze_timeout), 32'(v.tmo));
   endtask

   initial begin
      //                 rst ext br mr  xrt rs rt uses ctrl   st sc fc tmo
      tbl.push_back(mk(0, 1, 0, 1, 5, 5, 0, 0, C_OFF, 0, 0, 0, 0)); // reset with freeze+hz
      tbl.push_back(mk(0, 1, 0, 1, 5, 5, 0, 0, C_OFF, 0, 0, 0, 0));
      tbl.push_back(mk(1, 0, 0, 1, 5, 5, 0, 0, C_STL, 1, 1, 0, 0)); // load-use on rs
      tbl.push_back(mk(1, 0, 0, 0, 5, 5, 0, 0, C_RUN, 0, 1, 0, 0)); // bubble in ID/EX
      tbl.push_back(mk(1, 0, 0, 1, 0, 0, 0, 0, C_RUN, 0, 1, 0, 0)); // $0 never hazards
      tbl.push_back(mk(1, 0, 0, 1, 7, 3, 7, 0, C_RUN, 0, 1, 0, 0)); // rt not used
      tbl.push_back(mk(1, 0, 0, 1, 7, 3, 7, 1, C_STL, 1, 2, 0, 0)); // rt used
      tbl.push_back(mk(1, 0, 1, 1, 5, 5, 0, 0, C_FLS, 2, 2, 1, 0)); // branch beats hz
      tbl.push_back(mk(1, 1, 1, 0, 0, 0, 0, 0, C_FRZ, 3, 2, 1, 0)); // freeze 1..5
      tbl.push_back(mk(1, 1, 1, 0, 0, 0, 0, 0, C_FRZ, 3, 2, 1, 0));
      tbl.push_back(mk(1, 1, 1, 0, 0, 0, 0, 0, C_FRZ, 3, 2, 1, 0));
      tbl.push_back(mk(1, 1, 1, 0, 0, 0, 0, 0, C_FRZ, 3, 2, 1, 1));
      tbl.push_back(mk(1, 1, 1, 0, 0, 0, 0, 0, C_FRZ, 3, 2, 1, 1));
      tbl.push_back(mk(1, 0, 1, 0, 0, 0, 0, 0, C_FLS, 2, 2, 2, 1)); // deferred branch
      tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, C_RUN, 0, 2, 2, 1)); // timeout sticky
      tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, C_OFF, 0, 0, 0, 0)); // reset clears all
      for (int k = 0; k < 5; k++) begin                             // stall saturation
         logic [1:0] sc_exp;
         sc_exp = (k >= 2) ? 2'd3 : 2'(k + 1);
         tbl.push_back(mk(1, 0, 0, 1, 9, 9, 0, 0, C_STL, 1, sc_exp, 0, 0));
         tbl.push_back(mk(1, 0, 0, 0, 9, 9, 0, 0, C_RUN, 0, sc_exp, 0, 0));
      end
      tbl.push_back(mk(1, 1, 0, 0, 0, 0, 0, 0, C_FRZ, 3, 3, 0, 0));
      tbl.push_back(mk(0, 1, 0, 1, 9, 9, 0, 0, C_OFF, 0, 0, 0, 0)); // reset mid-freeze
      tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, C_RUN, 0, 0, 0, 0));

      drive(tbl[0]);
      for (int i = 0; i < tbl.size(); i++)
         apply(tbl[i], $sformatf("row%0d", i));

      // Back-to-back flushes saturate flush_cnt; freeze_run must restart after a break.
      for (int k = 0; k < 4; k++)
         apply(mk(1, 0, 1, 0, 0, 0, 0, 0, C_FLS, 2, 0, (k >= 2) ? 2'd3 : 2'(k + 1), 0),
               $sformatf("flush%0d", k));
      for (int k = 0; k < 3; k++)
         apply(mk(1, 1, 0, 0, 0, 0, 0, 0, C_FRZ, 3, 0, 3, 0), $sformatf("frzA%0d", k));
      apply(mk(1, 0, 0, 0, 0, 0, 0, 0, C_RUN, 0, 0, 3, 0), "frz_break");
      for (int k = 0; k < 3; k++)
         apply(mk(1, 1, 0, 0, 0, 0, 0, 0, C_FRZ, 3, 0, 3, 0), $sformatf("frzB%0d", k));
      apply(mk(1, 1, 0, 0, 0, 0, 0, 0, C_FRZ, 3, 0, 3, 1), "frzB3");

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
